// File: rtl/cpu_mem_pkg.sv
// Shared types and encodings for the CPU memory-port arbiter.
// Used by mem_arbiter and its optional watchdog (MEM_ARB_TIMEOUT_EN).
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic OWN_IF   = 1'b0;
  localparam logic OWN_LS   = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Round-robin pick: on a tie the requester that was not served last wins.
  function automatic logic rr_pick(input logic if_req, input logic ls_req,
                                   input logic last_gnt);
    if (if_req && ls_req) return ~last_gnt;
    else if (ls_req)      return OWN_LS;
    else                  return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// WAIT-state watchdog for mem_arbiter; only instantiated when
// MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_wdog
  #(parameter int TIMEOUT = 64)
  (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
  );

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (run && (count != CW'(TIMEOUT - 1)))
      count <= count + 1'b1;
  end

  // count holds completed WAIT cycles, so this fires on the TIMEOUT-th one.
  assign expired = run && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the MemControl port between IF and LS.
// Optional WAIT watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import cpu_mem_pkg::*;
  #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 64
  )
  (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AWIDTH-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DWIDTH-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [AWIDTH-1:0] ls_addr,
    input  logic [DWIDTH-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [DWIDTH-1:0] ls_rdata,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_rw,
    output logic              mem_valid,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              err
  );

  arb_state_t        state, state_next;
  logic              owner_q, last_gnt_q, rw_q, timed_out_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, if_rdata_q, ls_rdata_q;
  logic              win, timeout_hit;

  assign win = rr_pick(if_req, ls_req, last_gnt_q);

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == ISSUE),
    .run     (state == WAIT),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_IF;
      last_gnt_q  <= OWN_IF;
      rw_q        <= RW_WRITE;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      timed_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (if_req || ls_req) begin
          owner_q <= win;
          addr_q  <= (win == OWN_LS) ? ls_addr : if_addr;
          rw_q    <= (win == OWN_LS) ? ls_rw : RW_READ;
          wdata_q <= (win == OWN_LS && ls_rw == RW_WRITE) ? ls_wdata : '0;
        end
        WAIT: if (mem_ready) begin
          // A ready coinciding with the timeout still counts as success.
          if (rw_q == RW_READ) begin
            if (owner_q == OWN_LS) ls_rdata_q <= mem_rdata;
            else                   if_rdata_q <= mem_rdata;
          end
        end else if (timeout_hit) begin
          timed_out_q <= 1'b1;
        end
        DONE: begin
          last_gnt_q  <= owner_q;
          timed_out_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    ls_gnt     = 1'b0;
    if_done    = 1'b0;
    ls_done    = 1'b0;
    mem_valid  = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE:  if (if_req || ls_req) state_next = ISSUE;
      ISSUE: begin
        mem_valid  = 1'b1;
        if_gnt     = (owner_q == OWN_IF);
        ls_gnt     = (owner_q == OWN_LS);
        state_next = WAIT;
      end
      WAIT: begin
        if_gnt = (owner_q == OWN_IF);
        ls_gnt = (owner_q == OWN_LS);
        if (mem_ready || timeout_hit) state_next = DONE;
      end
      DONE: begin
        if_done    = (owner_q == OWN_IF);
        ls_done    = (owner_q == OWN_LS);
        err        = timed_out_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_rw    = rw_q;
  assign mem_wdata = (rw_q == RW_WRITE) ? wdata_q : '0;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model; define MEM_ARB_TIMEOUT_EN for watchdog tests.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TO = 4;
  localparam bit M_IF = 1'b0;
  localparam bit M_LS = 1'b1;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, ls_req, ls_rw, mem_ready;
  logic [AW-1:0] if_addr, ls_addr;
  logic [DW-1:0] ls_wdata, mem_rdata;
  logic          if_gnt, if_done, ls_gnt, ls_done;
  logic          mem_rw, mem_valid, err;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  // Reference model state: who was served last, and what each requester holds.
  bit            last_served;
  logic [DW-1:0] exp_if_rdata, exp_ls_rdata;

  mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_rw     (ls_rw),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_rw    (mem_rw),
    .mem_valid (mem_valid),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round robin from the rules: lone requester wins, a tie goes to the one not served last.
  function automatic bit pick_winner(input bit i_req, input bit l_req);
    if (i_req && l_req) return (last_served == M_IF) ? M_LS : M_IF;
    return l_req ? M_LS : M_IF;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl"}, {if_gnt, if_done, ls_gnt, ls_done, mem_rw, mem_valid, err}, 64'd0);
    check({tag, ".addr"}, 64'(mem_addr), 64'd0);
    check({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, ".rdata"}, {if_rdata, ls_rdata}, 64'd0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle.ctl", {if_gnt, ls_gnt, if_done, ls_done, mem_valid, err}, 64'd0);
    check("idle.rdata", {if_rdata, ls_rdata}, {exp_if_rdata, exp_ls_rdata});
  endtask

  // Called at an IDLE-cycle negedge with the requests already driven.
  task automatic do_txn(input bit w, input int d, input logic [DW-1:0] rd,
                        input bit give_ready, input bit exp_err);
    logic [AW-1:0] ea;
    logic          erw;
    logic [DW-1:0] ewd;
    ea  = w ? ls_addr : if_addr;
    erw = w ? ls_rw : 1'b1;
    ewd = erw ? '0 : ls_wdata;
    @(negedge clk);
    check("issue.valid", 64'(mem_valid), 64'd1);
    check("issue.addr", 64'(mem_addr), 64'(ea));
    check("issue.rw", 64'(mem_rw), 64'(erw));
    check("issue.wdata", 64'(mem_wdata), 64'(ewd));
    check("issue.gnt", {if_gnt, ls_gnt}, w ? 64'd1 : 64'd2);
    check("issue.done", {if_done, ls_done}, 64'd0);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      check("wait.valid", 64'(mem_valid), 64'd0);
      check("wait.held", {mem_addr, mem_rw}, {ea, erw});
      check("wait.gnt", {if_gnt, ls_gnt, if_done, ls_done}, w ? 64'd4 : 64'd8);
      mem_ready = (i == d) && give_ready;
      mem_rdata = (i == d) ? rd : $urandom;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    if (!exp_err && erw) begin
      if (w) exp_ls_rdata = rd;
      else   exp_if_rdata = rd;
    end
    check("done.pulse", {if_done, ls_done}, w ? 64'd1 : 64'd2);
    check("done.gnt", {if_gnt, ls_gnt, mem_valid}, 64'd0);
    check("done.err", 64'(err), 64'(exp_err));
    check("done.rdata", {if_rdata, ls_rdata}, {exp_if_rdata, exp_ls_rdata});
    last_served = w;
    if (w) ls_req = 1'b0;
    else   if_req = 1'b0;
  endtask

  initial begin
    bit w;
    reset = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_rw = 1'b1; mem_ready = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
    last_served = M_IF; exp_if_rdata = '0; exp_ls_rdata = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Both requesting from reset: strict LS, IF, LS, IF alternation.
    reset = 1'b0;
    if_req = 1'b1; if_addr = 10'h021;
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 10'h0A0;
    check("tie1.pick", 64'(pick_winner(if_req, ls_req)), 64'(M_LS));
    do_txn(M_LS, 0, 32'h1111_0001, 1'b1, 1'b0);
    idle_cycle();
    do_txn(M_IF, 1, 32'h2222_0002, 1'b1, 1'b0);
    idle_cycle();
    if_req = 1'b1; if_addr = 10'h033;
    ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 10'h0B4; ls_wdata = 32'hCAFE_F00D;
    do_txn(M_LS, 2, 32'h3333_0003, 1'b1, 1'b0);
    idle_cycle();
    do_txn(M_IF, 0, 32'h4444_0004, 1'b1, 1'b0);
    idle_cycle();

    // IF fetch at 0x005, ready two cycles after valid.
    if_req = 1'b1; if_addr = 10'h005;
    do_txn(M_IF, 1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("if_fetch.rdata", 64'(if_rdata), 64'hDEAD_BEEF);
    idle_cycle();

    // LS store: write data goes out, ls_rdata untouched.
    ls_req = 1'b1; ls_rw = 1'b0; ls_addr = 10'h010; ls_wdata = 32'h1234_5678;
    do_txn(M_LS, 0, 32'h5555_AAAA, 1'b1, 1'b0);
    check("store.ls_rdata", 64'(ls_rdata), 64'h1111_0001);
    idle_cycle();

    // Reset while in WAIT: everything clears, no done afterwards.
    if_req = 1'b1; if_addr = 10'h077;
    @(negedge clk);
    check("rst_issue.valid", 64'(mem_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("rst_wait");
    reset = 1'b0; if_req = 1'b0;
    last_served = M_IF; exp_if_rdata = '0; exp_ls_rdata = '0;
    idle_cycle();
    idle_cycle();
    if_req = 1'b1; if_addr = 10'h0C8;
    do_txn(M_IF, 0, 32'h0BAD_CAFE, 1'b1, 1'b0);
    idle_cycle();

`ifdef MEM_ARB_TIMEOUT_EN
    // No ready for TIMEOUT WAIT cycles: done and err together, data kept.
    if_req = 1'b1; if_addr = 10'h111;
    do_txn(M_IF, TO - 1, 32'hFFFF_0000, 1'b0, 1'b1);
    idle_cycle();
    // Ready exactly on the last allowed WAIT cycle is a success.
    if_req = 1'b1; if_addr = 10'h112;
    do_txn(M_IF, TO - 1, 32'h600D_DA7A, 1'b1, 1'b0);
    idle_cycle();
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 10'h113;
    do_txn(M_LS, TO - 1, 32'hEEEE_1111, 1'b0, 1'b1);
    idle_cycle();
`else
    // Without the watchdog a long WAIT still completes without err.
    ls_req = 1'b1; ls_rw = 1'b1; ls_addr = 10'h1F0;
    do_txn(M_LS, 9, 32'h7777_8888, 1'b1, 1'b0);
    idle_cycle();
`endif

    // Randomized traffic; each iteration starts on an IDLE-cycle negedge.
    for (int n = 0; n < 60; n++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = AW'($urandom);
      end
      if (!ls_req && $urandom_range(0, 1) == 1) begin
        ls_req = 1'b1; ls_rw = 1'($urandom_range(0, 1));
        ls_addr = AW'($urandom); ls_wdata = $urandom;
      end
      if (if_req || ls_req) begin
        w = pick_winner(if_req, ls_req);
        do_txn(w, $urandom_range(0, 3), $urandom, 1'b1, 1'b0);
      end
      idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single MemControl handshake port (address, RW, Valid, Ready, data) between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the CPU sequencing FSMs and MemControl/RAM.
- Performs round-robin arbitration and sequences one memory transaction at a time.
- Latches read data and returns a one-cycle completion pulse to the winning requester.

Parameters:
DWIDTH, 32, data word width
AWIDTH, 10, address width (matches MAR)
TIMEOUT, 64, max cycles in WAIT before forced abort (used only with optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  AWIDTH  fetch address, stable while if_req high
if_gnt  out  1  high while IF owns the memory port
if_done  out  1  one-cycle pulse, fetch complete
if_rdata  out  DWIDTH  fetched word, valid from if_done until next IF grant
ls_req  in  1  load/store request, level, held until ls_done
ls_rw  in  1  1 = read (load), 0 = write (store)
ls_addr  in  AWIDTH  load/store address
ls_wdata  in  DWIDTH  store data
ls_gnt  out  1  high while LS owns the memory port
ls_done  out  1  one-cycle pulse, load/store complete
ls_rdata  out  DWIDTH  loaded word, valid from ls_done until next LS grant
mem_addr  out  AWIDTH  to MemControl address
mem_rw  out  1  to MemControl RW (1 = read)
mem_valid  out  1  to MemControl Valid, one-cycle pulse
mem_wdata  out  DWIDTH  write data, driven only while mem_rw = 0
mem_ready  in  1  from MemControl, transaction finished
mem_rdata  in  DWIDTH  read data from MemControl
err  out  1  one-cycle pulse with done when a transaction timed out; constant 0 without the feature

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Reset -> IDLE.
- Reset values: all outputs 0; last_gnt = IF, so a tie at the first arbitration goes to LS.
- IDLE:
  - Sample if_req/ls_req.
  - One request -> grant it.
  - Both requests -> grant the one not equal to last_gnt.
  - On grant: register owner, addr, rw (IF always read), wdata; assert gnt; go to ISSUE next cycle.
  - No request -> stay in IDLE.
- ISSUE:
  - mem_valid = 1 for exactly this cycle; mem_addr/mem_rw/mem_wdata driven from registered values.
  - mem_ready is ignored in this state.
  - Go to WAIT.
- WAIT:
  - mem_valid = 0; address/rw held.
  - On mem_ready = 1: capture mem_rdata into owner's rdata if read; go to DONE.
- DONE:
  - Pulse owner's done; deassert gnt; update last_gnt = owner; go to IDLE.
  - rdata updates in the same cycle done rises.
- Latency: req seen in IDLE at cycle N -> valid at N+1 -> ready at cycle M (M >= N+2) -> done at M+1. Minimum request-to-done is 3 cycles.
- Back-to-back: a requester must drop req in the cycle it sees done. A req still high in the following IDLE cycle is a new request.
- A non-owner's request is held pending and never dropped; round-robin bounds waiting to one transaction.
- gnt outputs are mutually exclusive (one-hot or zero).
- mem_wdata = 0 whenever mem_rw = 1.
- Write data is never returned: ls_rdata is unchanged on stores.
- Reset asserted mid-transaction (any state): next cycle IDLE, all outputs 0, no done pulse. Any pending MemControl operation is abandoned.
- Requests deasserted during ISSUE/WAIT are ignored; the transaction completes and done still pulses.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no mem_ready: go to DONE, pulse owner's done and err together, leave rdata unchanged.
  - mem_ready arriving in the same cycle the count hits TIMEOUT counts as success (err = 0).
- Without the macro: no counter; WAIT is unbounded; err tied to 0.

Decomposition:
- Shared package cpu_mem_pkg:
  - enum arb_state_t {IDLE, ISSUE, WAIT, DONE}
  - owner encoding constants OWN_IF = 1'b0, OWN_LS = 1'b1
  - RW_READ = 1'b1, RW_WRITE = 1'b0
- One natural sub-module: mem_arb_wdog, the timeout counter, instantiated only under MEM_ARB_TIMEOUT_EN.
- Arbitration and FSM stay in the top module.

Test Plan:
- IF only, if_addr = 0x005, mem_ready 2 cycles after valid, mem_rdata = 0xDEADBEEF -> mem_valid pulses once with mem_rw = 1, mem_addr = 0x005; if_done 1 cycle after ready; if_rdata = 0xDEADBEEF.
- LS store, ls_addr = 0x010, ls_wdata = 0x12345678 -> mem_rw = 0, mem_wdata = 0x12345678; ls_done pulses; ls_rdata unchanged; err = 0.
- if_req and ls_req both high from reset -> LS granted first, IF second; then both high again -> LS granted first again (strict alternation over 4 transactions).
- Reset asserted during WAIT -> next cycle all outputs 0, state IDLE, no done pulse; subsequent IF request completes normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT = 4, mem_ready never asserts -> done and err pulse together 4 WAIT cycles in, rdata unchanged; ready exactly on the 4th WAIT cycle -> err = 0, data captured.
